// File: rtl/mem_bus_arbiter.sv
// Round-robin two-requester sequencer for the byte-wide memory bus; write done at t+2, read done at t+2+RD_LATENCY.
// Requesters hold req until their done pulse; define PARITY_CHECK_EN to flag even-parity errors on read data.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              perr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W:0]   mem_data_out
);
  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              perr_q, perr_d;
  logic              mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              rd_perr;

`ifdef PARITY_CHECK_EN
  assign rd_perr = (^mem_data_out[DATA_W-1:0]) != mem_data_out[DATA_W];
`else
  logic unused_parity;
  assign unused_parity = mem_data_out[DATA_W];
  assign rd_perr       = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    rdata_d       = rdata_q;
    perr_d        = 1'b0;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    mem_address_d = '0;
    mem_data_in_d = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not win the previous tie goes first
          gnt_d = (req0 && req1) ? ~last_q : req1;
          if (req0 && req1) last_d = gnt_d;
          we_d          = gnt_d ? we1 : we0;
          addr_d        = gnt_d ? addr1 : addr0;
          wdata_d       = gnt_d ? wdata1 : wdata0;
          mem_write_d   = we_d;
          mem_read_d    = ~we_d;
          mem_address_d = addr_d;
          mem_data_in_d = we_d ? wdata_d : '0;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          done0_d = ~gnt_q;
          done1_d = gnt_q;
          rdata_d = mem_data_out[DATA_W-1:0];
          perr_d  = rd_perr;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata_q       <= '0;
      perr_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rdata_q       <= rdata_d;
      perr_q        <= perr_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
    end
  end

  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign perr        = perr_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 uses RD_LATENCY=1, instance 1 uses RD_LATENCY=3.
// A transaction-level predictor derives every expected output cycle from the arbitration and timing rules.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic        req0 [2], req1 [2], we0 [2], we1 [2];
  logic [15:0] addr0 [2], addr1 [2];
  logic [7:0]  wdata0 [2], wdata1 [2];
  logic        done0 [2], done1 [2], perr [2], mem_write [2], mem_read [2];
  logic [7:0]  rdata [2], mem_data_in [2];
  logic [15:0] mem_address [2];
  logic [8:0]  mdo [2];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
      .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
      .done0(done0[g]), .done1(done1[g]), .rdata(rdata[g]), .perr(perr[g]),
      .mem_write(mem_write[g]), .mem_read(mem_read[g]),
      .mem_address(mem_address[g]), .mem_data_in(mem_data_in[g]),
      .mem_data_out(mdo[g])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Power-up memory image: a few locations carry deliberately wrong parity
  function automatic logic [8:0] init_val(input logic [7:0] a);
    logic [7:0] d;
    if (a == 8'h42) return 9'h03C;
    if (a == 8'h43) return 9'h13C;
    d = a ^ 8'h5A;
    return {(^d) ^ (a[2:0] == 3'd5), d};
  endfunction

  function automatic bit par_bad(input logic [8:0] v);
    bit bad;
    bad = (^v[7:0]) != v[8];
`ifndef PARITY_CHECK_EN
    bad = 1'b0;
`endif
    return bad;
  endfunction

  // Memory slave: read data appears RD_LATENCY cycles after the read strobe, noise otherwise
  bit          swr [2][256];
  logic [8:0]  sdat [2][256];
  bit   [2:0]  pv [2];
  logic [8:0]  pd [2][3];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_write[k] === 1'b1) begin
        swr[k][mem_address[k][7:0]]  <= 1'b1;
        sdat[k][mem_address[k][7:0]] <= {^mem_data_in[k], mem_data_in[k]};
      end
      pv[k]    <= {pv[k][1:0], mem_read[k] === 1'b1};
      pd[k][0] <= swr[k][mem_address[k][7:0]] ? sdat[k][mem_address[k][7:0]] : init_val(mem_address[k][7:0]);
      pd[k][1] <= pd[k][0];
      pd[k][2] <= pd[k][1];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++)
      mdo[k] = pv[k][lat(k)-1] ? pd[k][lat(k)-1] : 9'($urandom);
  end

  // Reference predictor state
  bit          act [2], win [2], twe [2], last_m [2];
  int          t_s [2], d_cy [2], free_at [2];
  logic [15:0] taddr [2];
  logic [7:0]  twd [2], rd_hold [2];
  logic [8:0]  exp_rd [2];
  bit          mwr [2][256];
  logic [8:0]  mdat [2][256];
  int          cnt [2][2];
  bit          all_w;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s inst%0d cycle %0d: observed %0h expected %0h", tag, k, cyc, obs, expv);
    end
  endtask

  task automatic set_cmd(input int k, input int r, input logic rq, input logic w,
                         input logic [15:0] a, input logic [7:0] d);
    if (r == 0) begin
      req0[k] = rq; we0[k] = w; addr0[k] = a; wdata0[k] = d;
    end else begin
      req1[k] = rq; we1[k] = w; addr1[k] = a; wdata1[k] = d;
    end
  endtask

  task automatic new_cmd(input int k, input int r);
    logic w;
    w = all_w ? 1'b1 : 1'($urandom_range(0, 1));
    set_cmd(k, r, 1'b1, w, {8'($urandom), 4'h0, 4'($urandom)}, 8'($urandom));
  endtask

  task automatic start(input int k, input int r, input int n, input logic w,
                       input logic [15:0] a, input logic [7:0] d);
    cnt[k][r] = n;
    set_cmd(k, r, 1'b1, w, a, d);
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 2; r++) begin
        cnt[k][r] = 0;
        set_cmd(k, r, 1'b0, 1'b0, 16'h0, 8'h0);
      end
  endtask

  task automatic check(input int k);
    bit at_iss, at_done;
    at_iss  = act[k] && (cyc == t_s[k] + 1);
    at_done = act[k] && (cyc == d_cy[k]);
    if (at_done && !twe[k]) rd_hold[k] = exp_rd[k][7:0];
    chk("mem_write", k, 32'(mem_write[k]), 32'(at_iss && twe[k]));
    chk("mem_read", k, 32'(mem_read[k]), 32'(at_iss && !twe[k]));
    chk("mem_address", k, 32'(mem_address[k]), 32'(at_iss ? taddr[k] : 16'h0));
    chk("mem_data_in", k, 32'(mem_data_in[k]), 32'((at_iss && twe[k]) ? twd[k] : 8'h0));
    chk("done0", k, 32'(done0[k]), 32'(at_done && !win[k]));
    chk("done1", k, 32'(done1[k]), 32'(at_done && win[k]));
    chk("rdata", k, 32'(rdata[k]), 32'(rd_hold[k]));
    chk("perr", k, 32'(perr[k]), 32'(at_done && !twe[k] && par_bad(exp_rd[k])));
    chk("strobe_excl", k, 32'(mem_write[k] & mem_read[k]), 32'(0));
  endtask

  // Check the outputs of this cycle, then let completed requesters move on
  task automatic cyc_begin();
    int r;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      check(k);
      if (act[k] && cyc == d_cy[k]) begin
        r = int'(win[k]);
        cnt[k][r]--;
        if (cnt[k][r] > 0) new_cmd(k, r);
        else set_cmd(k, r, 1'b0, 1'b0, 16'h0, 8'h0);
      end
    end
  endtask

  // Predict what the arbiter does with the inputs now applied for this cycle
  task automatic cyc_end();
    bit w;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        act[k] = 1'b0; rd_hold[k] = 8'h0; last_m[k] = 1'b1; free_at[k] = cyc + 1;
      end else if (cyc >= free_at[k] && (req0[k] || req1[k])) begin
        w = (req0[k] && req1[k]) ? !last_m[k] : req1[k];
        if (req0[k] && req1[k]) last_m[k] = w;
        win[k]   = w;
        twe[k]   = w ? we1[k] : we0[k];
        taddr[k] = w ? addr1[k] : addr0[k];
        twd[k]   = w ? wdata1[k] : wdata0[k];
        act[k]   = 1'b1;
        t_s[k]   = cyc;
        d_cy[k]  = twe[k] ? cyc + 2 : cyc + 2 + lat(k);
        free_at[k] = d_cy[k] + 1;
        if (twe[k]) begin
          mwr[k][taddr[k][7:0]]  = 1'b1;
          mdat[k][taddr[k][7:0]] = {^twd[k], twd[k]};
        end else begin
          exp_rd[k] = mwr[k][taddr[k][7:0]] ? mdat[k][taddr[k][7:0]] : init_val(taddr[k][7:0]);
        end
      end
    end
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (cyc < free_at[k] || cnt[k][0] > 0 || cnt[k][1] > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic run(input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      tick();
      n++;
    end
    chk("timeout", 0, 32'(busy()), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    all_w = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_hold[k] = 8'h0;
      last_m[k]  = 1'b1;
    end
    clear_reqs();

    // Reset state
    repeat (2) tick();
    cyc_begin(); reset = 1'b0; cyc_end();
    repeat (2) tick();

    // Single write on requester 0
    cyc_begin(); start(0, 0, 1, 1'b1, 16'h1234, 8'hA5); cyc_end();
    run(50);

    // Single read on requester 1, latency 1, good parity
    cyc_begin(); start(0, 1, 1, 1'b0, 16'h0042, 8'h00); cyc_end();
    run(50);

    // Read of a location with bad parity on both instances
    cyc_begin();
    start(0, 0, 1, 1'b0, 16'h0043, 8'h00);
    start(1, 1, 1, 1'b0, 16'h0043, 8'h00);
    cyc_end();
    run(50);

    // Both requesters hold write requests: grants must alternate
    all_w = 1'b1;
    cyc_begin();
    start(0, 0, 2, 1'b1, 16'h0001, 8'h11);
    start(0, 1, 2, 1'b1, 16'h0002, 8'h22);
    cyc_end();
    run(80);
    all_w = 1'b0;

    // Latency-3 read of a previously unwritten location
    cyc_begin(); start(1, 0, 1, 1'b0, 16'h0005, 8'h00); cyc_end();
    run(50);

    // Reset while a latency-3 read is waiting for data
    cyc_begin(); start(1, 0, 1, 1'b0, 16'h0007, 8'h00); cyc_end();
    tick();
    tick();
    cyc_begin(); reset = 1'b1; clear_reqs(); cyc_end();
    cyc_begin(); reset = 1'b0; cyc_end();
    repeat (6) tick();
    cyc_begin(); start(1, 0, 1, 1'b0, 16'h0009, 8'h00); cyc_end();
    run(50);

    // Randomised traffic on both instances, with staggered second requesters
    for (int round = 0; round < 16; round++) begin
      cyc_begin();
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 2; r++)
          if ($urandom_range(0, 1) == 1) begin
            start(k, r, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                  {8'($urandom), 4'h0, 4'($urandom)}, 8'($urandom));
          end
      cyc_end();
      repeat ($urandom_range(0, 3)) tick();
      cyc_begin();
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < 2; r++)
          if (cnt[k][r] == 0 && $urandom_range(0, 1) == 1) begin
            start(k, r, $urandom_range(1, 2), 1'($urandom_range(0, 1)),
                  {8'($urandom), 4'h0, 4'($urandom)}, 8'($urandom));
          end
      cyc_end();
      run(400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
